// File: rtl/mac_top_level_if.sv
// Operand/result bundle between a MAC client and the MAC engine.
interface mac_top_level_if #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 25
);
  logic                    valid_input;
  logic                    last_input;
  logic                    mode;
  logic signed [IN_W-1:0]  num_a;
  logic signed [IN_W-1:0]  num_x;
  logic signed [IN_W-1:0]  num_b;
  logic signed [IN_W-1:0]  num_c;
  logic signed [OUT_W-1:0] final_output;
  logic                    valid_output;

  modport master (
    output valid_input, last_input, mode, num_a, num_x, num_b, num_c,
    input  final_output, valid_output
  );

  modport slave (
    input  valid_input, last_input, mode, num_a, num_x, num_b, num_c,
    output final_output, valid_output
  );
endinterface

// File: rtl/mac_top_level.sv
// Signed MAC engine: trinomial (a*x+b)*x+c (mode=1) or running sum of products (mode=0).
//  state  | meaning
//  IDLE   | waiting for valid_input
//  TRI_S1 | trinomial: computing p1 = a*x + b
//  TRI_S2 | trinomial: computing p1*x + c, result edge
//  OUT    | valid_output high this cycle; accepts a new input like IDLE
module mac_top_level #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 25
) (
  input logic            clk,
  input logic            reset,
  mac_top_level_if.slave bus
);
  localparam int P1_W = 2*IN_W + 1;

  typedef enum logic [1:0] {IDLE, TRI_S1, TRI_S2, OUT} state_t;

  state_t state, state_n;
  logic   accept;
  logic   set_valid;

  logic                    mode_q;
  logic signed [IN_W-1:0]  a_q, x_q, b_q, c_q;
  logic signed [P1_W-1:0]  p1_q;
  logic signed [OUT_W-1:0] acc_q;

  logic signed [P1_W-1:0]  a_p, x_p, b_p, p1_d;
  logic signed [OUT_W-1:0] a_in_o, x_in_o, acc_base, sump_sum;
  logic signed [OUT_W-1:0] p1_o, x_o, c_o, tri_res;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n   = state;
    accept    = 1'b0;
    set_valid = 1'b0;
    case (state)
      IDLE, OUT: begin
        state_n = IDLE;
        if (bus.valid_input) begin
          accept = 1'b1;
          if (bus.mode) begin
            state_n = TRI_S1;
          end else if (bus.last_input) begin
            state_n   = OUT;
            set_valid = 1'b1;
          end
        end
      end
      TRI_S1: state_n = TRI_S2;
      TRI_S2: begin
        state_n   = OUT;
        set_valid = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  // All products are formed at full result width; the true values always fit, so no truncation occurs.
  assign a_in_o   = {{(OUT_W-IN_W){bus.num_a[IN_W-1]}}, bus.num_a};
  assign x_in_o   = {{(OUT_W-IN_W){bus.num_x[IN_W-1]}}, bus.num_x};
  assign acc_base = (bus.mode == mode_q) ? acc_q : '0;
  assign sump_sum = acc_base + a_in_o * x_in_o;

  assign a_p  = {{(P1_W-IN_W){a_q[IN_W-1]}}, a_q};
  assign x_p  = {{(P1_W-IN_W){x_q[IN_W-1]}}, x_q};
  assign b_p  = {{(P1_W-IN_W){b_q[IN_W-1]}}, b_q};
  assign p1_d = a_p * x_p + b_p;

  assign p1_o    = {{(OUT_W-P1_W){p1_q[P1_W-1]}}, p1_q};
  assign x_o     = {{(OUT_W-IN_W){x_q[IN_W-1]}}, x_q};
  assign c_o     = {{(OUT_W-IN_W){c_q[IN_W-1]}}, c_q};
  assign tri_res = p1_o * x_o + c_o;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q           <= 1'b0;
      a_q              <= '0;
      x_q              <= '0;
      b_q              <= '0;
      c_q              <= '0;
      p1_q             <= '0;
      acc_q            <= '0;
      bus.final_output <= '0;
      bus.valid_output <= 1'b0;
    end else begin
      bus.valid_output <= set_valid;
      if (accept) begin
        mode_q <= bus.mode;
        a_q    <= bus.num_a;
        x_q    <= bus.num_x;
        b_q    <= bus.num_b;
        c_q    <= bus.num_c;
        if (!bus.mode) begin
          acc_q            <= sump_sum;
          bus.final_output <= sump_sum;
        end else if (!mode_q) begin
          acc_q <= '0;
        end
      end
      if (state == TRI_S1) p1_q <= p1_d;
      if (state == TRI_S2) bus.final_output <= tri_res;
    end
  end
endmodule

// File: tb/tb_mac_top_level.sv
// Bench for mac_top_level: directed vector table, corner sequences, and random ops against a reference model.
module tb_mac_top_level;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mac_top_level_if bus ();
  mac_top_level dut (.clk(clk), .reset(reset), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;
  int last_result = 0;

  typedef struct {
    bit                 mode;
    bit                 last;
    logic signed [7:0]  a, x, b, c;
    int                 exp;
  } vec_t;

  vec_t vecs[12];

  // reference model state
  int acc_m = 0;
  bit pm_m  = 1'b0;

  function automatic vec_t mk(bit m, bit l, int a, int x, int b, int c, int e);
    vec_t v;
    v.mode = m; v.last = l;
    v.a = 8'(a); v.x = 8'(x); v.b = 8'(b); v.c = 8'(c);
    v.exp = e;
    return v;
  endfunction

  function automatic int wrap25(longint v);
    logic [24:0] t;
    t = v[24:0];
    return int'($signed(t));
  endfunction

  task automatic check(input string name, input longint got, input longint exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit m, input bit l, input logic signed [7:0] a, x, b, c);
    bus.valid_input = 1'b1;
    bus.mode = m;
    bus.last_input = l;
    bus.num_a = a; bus.num_x = x; bus.num_b = b; bus.num_c = c;
  endtask

  task automatic do_reset;
    bus.valid_input = 1'b0;
    reset = 1'b1;
    #1;
    check("reset_final", bus.final_output, 0);
    check("reset_valid", bus.valid_output, 0);
    tick;
    tick;
    reset = 1'b0;
    last_result = 0;
    acc_m = 0;
    pm_m = 1'b0;
  endtask

  task automatic run_tri(input logic signed [7:0] a, x, b, c, input int exp, input bit junk);
    drive(1'b1, 1'($urandom_range(0, 1)), a, x, b, c);
    tick;
    check("tri_e0_valid", bus.valid_output, 0);
    check("tri_e0_hold", bus.final_output, last_result);
    if (junk) drive(1'($urandom_range(0, 1)), 1'b1, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    else bus.valid_input = 1'b0;
    tick;
    bus.valid_input = 1'b0;
    check("tri_e1_valid", bus.valid_output, 0);
    check("tri_e1_hold", bus.final_output, last_result);
    tick;
    check("tri_valid", bus.valid_output, 1);
    check("tri_result", bus.final_output, exp);
    last_result = exp;
  endtask

  task automatic run_sump(input logic signed [7:0] a, x, input bit l, input int exp);
    drive(1'b0, l, a, x, 8'($urandom), 8'($urandom));
    tick;
    bus.valid_input = 1'b0;
    check("sump_result", bus.final_output, exp);
    check("sump_valid", bus.valid_output, l);
    last_result = exp;
    if (l) begin
      tick;
      check("sump_pulse_end", bus.valid_output, 0);
      check("sump_hold", bus.final_output, exp);
    end
  endtask

  // model-driven ops
  task automatic model_tri(input logic signed [7:0] a, x, b, c, input bit junk);
    int ai, xi, bi, ci;
    ai = a; xi = x; bi = b; ci = c;
    if (pm_m != 1'b1) acc_m = 0;
    pm_m = 1'b1;
    run_tri(a, x, b, c, (ai * xi + bi) * xi + ci, junk);
  endtask

  task automatic model_sump(input logic signed [7:0] a, x, input bit l);
    int ai, xi;
    ai = a; xi = x;
    if (pm_m != 1'b0) acc_m = 0;
    pm_m = 1'b0;
    acc_m = wrap25(longint'(acc_m) + longint'(ai * xi));
    run_sump(a, x, l, acc_m);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.valid_input = 1'b0;
    bus.last_input = 1'b0;
    bus.mode = 1'b0;
    bus.num_a = '0; bus.num_x = '0; bus.num_b = '0; bus.num_c = '0;

    vecs[0]  = mk(1, 0,   -5,   -3,  -2,  -1,      -40);
    vecs[1]  = mk(1, 0,    9,    8,   7,   6,      638);
    vecs[2]  = mk(1, 0,  127, -128, 127, 127,  2064639);
    vecs[3]  = mk(1, 0, -128, -128, 127, 127, -2113281);
    vecs[4]  = mk(0, 1,    2,    3,   0,   0,        6);
    vecs[5]  = mk(0, 0,    3,    4,   0,   0,       18);
    vecs[6]  = mk(0, 1,   -2,    5,   0,   0,        8);
    vecs[7]  = mk(0, 1,    1,    1,   0,   0,        9);
    vecs[8]  = mk(1, 0,    1,    1,   1,   1,        3);
    vecs[9]  = mk(0, 0,    3,    4,   0,   0,       12);
    vecs[10] = mk(0, 1,   -2,    5,   0,   0,        2);
    vecs[11] = mk(0, 1,    1,    1,   0,   0,        3);

    do_reset;
    // TRI results are taken back-to-back: each next op is accepted on the third edge after the previous accept
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].mode) run_tri(vecs[i].a, vecs[i].x, vecs[i].b, vecs[i].c, vecs[i].exp, 1'b0);
      else run_sump(vecs[i].a, vecs[i].x, vecs[i].last, vecs[i].exp);
    end

    // busy ignore: second valid_input during TRI must not disturb the result
    do_reset;
    run_tri(8'sd9, 8'sd8, 8'sd7, 8'sd6, 638, 1'b1);
    tick;
    check("busy_pulse_end", bus.valid_output, 0);
    check("busy_hold", bus.final_output, 638);

    // reset in the middle of a TRI op aborts it and clears the accumulator
    do_reset;
    run_sump(8'sd5, 8'sd5, 1'b0, 25);
    drive(1'b1, 1'b0, 8'sd3, 8'sd3, 8'sd3, 8'sd3);
    tick;
    bus.valid_input = 1'b0;
    reset = 1'b1;
    #1;
    check("abort_final", bus.final_output, 0);
    check("abort_valid", bus.valid_output, 0);
    #2;
    reset = 1'b0;
    last_result = 0;
    for (int i = 0; i < 4; i++) begin
      tick;
      check("abort_no_pulse", bus.valid_output, 0);
      check("abort_final_hold", bus.final_output, 0);
    end
    run_sump(8'sd2, 8'sd3, 1'b1, 6);

    // randomized ops against the model
    do_reset;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 1) == 1)
        model_tri(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
      else
        model_sump(8'($urandom), 8'($urandom), ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 3) == 0) tick;
    end

    // long SUMP run of extreme products to cross the 25-bit wrap
    for (int i = 0; i < 1100; i++) model_sump(-8'sd128, -8'sd128, 1'b0);
    model_sump(8'sd127, -8'sd128, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
